// File: rtl/arb4_rr_ctrl.sv
// Four-way round-robin arbiter feeding one registered valid/ready output channel.
// Optional ARB4_RR_LOCK_EN adds req_lock so a granted requester can keep top priority.
module arb4_rr_ctrl #(
    parameter int BIT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             req_valid,
`ifdef ARB4_RR_LOCK_EN
    input  logic [3:0]             req_lock,
`endif
    input  logic [4*BIT_WIDTH-1:0] req_data,
    output logic [3:0]             req_ready,
    output logic                   out_valid,
    output logic [BIT_WIDTH-1:0]   out_data,
    output logic [1:0]             out_src,
    input  logic                   out_ready,
    output logic                   busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           ptr_q, ptr_d;
    logic                 out_valid_q, out_valid_d;
    logic [BIT_WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]           out_src_q, out_src_d;

    logic [1:0]           grant_s;
    logic                 any_req_s;
    logic                 load_en_s;
    logic                 transfer_s;
    logic [1:0]           ptr_next_s;

    // Priority scan from ptr; iterating backwards lets the closest requester win.
    always_comb begin
        grant_s   = 2'd0;
        any_req_s = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (req_valid[ptr_q + 2'(k)]) begin
                grant_s   = ptr_q + 2'(k);
                any_req_s = 1'b1;
            end else begin
                grant_s   = grant_s;
                any_req_s = any_req_s;
            end
        end
    end

    // State register and output datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    // Next-state logic: a full register empties only when drained with nothing to refill it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (transfer_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FULL: begin
                if (out_ready && !any_req_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: load enable and the one-hot grant, forced low while reset is held.
    always_comb begin
        load_en_s = 1'b0;
        case (state_q)
            ST_IDLE: load_en_s = 1'b1;
            ST_FULL: load_en_s = out_ready;
            default: load_en_s = 1'b0;
        endcase
        transfer_s = load_en_s & any_req_s;
        if (rst_n && transfer_s) begin
            req_ready = 4'b0001 << grant_s;
        end else begin
            req_ready = 4'b0000;
        end
    end

    // Pointer advance; a locked grant keeps its own slot as top priority.
    always_comb begin
`ifdef ARB4_RR_LOCK_EN
        if (req_lock[grant_s]) begin
            ptr_next_s = grant_s;
        end else begin
            ptr_next_s = grant_s + 2'd1;
        end
`else
        ptr_next_s = grant_s + 2'd1;
`endif
    end

    // Output register load/drain; data and source hold when the register empties.
    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (transfer_s) begin
            ptr_d       = ptr_next_s;
            out_valid_d = 1'b1;
            out_data_d  = req_data[grant_s*BIT_WIDTH +: BIT_WIDTH];
            out_src_d   = grant_s;
        end else if ((state_q == ST_FULL) && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign busy      = out_valid_q;

endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Randomised and directed bench for arb4_rr_ctrl against a queue-free behavioural model.
// Build with ARB4_RR_LOCK_EN defined to also exercise the lock feature.
module tb_arb4_rr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_lock;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_ready;
    logic        busy;

    int tests_run = 0;
    int fails     = 0;

    int         m_ptr;
    bit         m_full;
    logic [7:0] m_data;
    logic [1:0] m_src;

    arb4_rr_ctrl #(.BIT_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
`ifdef ARB4_RR_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int g;
        g = rr_pick(req_valid, m_ptr);
        if (!rst_n || g < 0 || (m_full && !out_ready)) return 4'b0000;
        return 4'(1 << g);
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_full = 1'b0;
        m_data = 8'h00;
        m_src  = 2'd0;
    endtask

    // Advance the model with the current inputs, then move to just after the next edge.
    task automatic tick();
        int g;
        bit lk;
        if (rst_n) begin
            g = rr_pick(req_valid, m_ptr);
            if (g >= 0 && (!m_full || out_ready)) begin
                m_data = req_data[g*8 +: 8];
                m_src  = 2'(g);
                m_full = 1'b1;
                lk     = 1'b0;
`ifdef ARB4_RR_LOCK_EN
                lk     = req_lock[g];
`endif
                m_ptr  = lk ? g : (g + 1) % 4;
            end else if (m_full && out_ready) begin
                m_full = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_lock  = 4'b0000;
        out_ready = 1'b0;
        req_data  = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_lock  = 4'b0000;
        out_ready = 1'b1;
        req_data  = 32'hDEADBEEF;
        model_reset();
        #2;
        tests_run++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests_run++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        tests_run++; if (out_src !== 2'd0) begin fails++; $display("FAIL reset_out_src got=%0d exp=0", out_src); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 4'b0000;
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        req_data  = 32'h00A50000;
        out_ready = 1'b1;
        #1;
        tests_run++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
        tick();
        tests_run++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        tests_run++; if (out_data !== 8'hA5) begin fails++; $display("FAIL single_data got=%h exp=a5", out_data); end
        tests_run++; if (out_src !== 2'd2) begin fails++; $display("FAIL single_src got=%0d exp=2", out_src); end
        req_valid = 4'b1111;
        #1;
        tests_run++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL single_ptr3 got=%b exp=1000", req_ready); end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_rotation();
        do_reset();
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_data = $urandom;
            #1;
            tests_run++; if (req_ready !== 4'(1 << (k % 4))) begin fails++; $display("FAIL rot_ready[%0d] got=%b exp=%b", k, req_ready, 4'(1 << (k % 4))); end
            tick();
            tests_run++; if (out_valid !== 1'b1 || out_src !== 2'(k % 4) || out_data !== m_data) begin
                fails++; $display("FAIL rot_out[%0d] got v=%b src=%0d d=%h exp v=1 src=%0d d=%h", k, out_valid, out_src, out_data, k % 4, m_data);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        do_reset();
        req_valid = 4'b0010;
        req_data  = $urandom;
        out_ready = 1'b1;
        #1;
        tick();
        held = req_data[15:8];
        tests_run++; if (out_src !== 2'd1 || out_data !== held) begin fails++; $display("FAIL bp_load got src=%0d d=%h exp src=1 d=%h", out_src, out_data, held); end
        out_ready = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            req_data = $urandom;
            #1;
            tests_run++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, req_ready); end
            tick();
            tests_run++; if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== held) begin
                fails++; $display("FAIL bp_hold[%0d] got v=%b src=%0d d=%h exp v=1 src=1 d=%h", k, out_valid, out_src, out_data, held);
            end
        end
        out_ready = 1'b1;
        #1;
        tests_run++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL bp_release got=%b exp=0100", req_ready); end
        tick();
        tests_run++; if (out_src !== 2'd2 || out_data !== req_data[23:16]) begin fails++; $display("FAIL bp_next got src=%0d d=%h exp src=2 d=%h", out_src, out_data, req_data[23:16]); end
    endtask

    task automatic test_drain();
        logic [7:0] prev;
        prev      = out_data;
        req_valid = 4'b0000;
        out_ready = 1'b1;
        #1;
        tick();
        tests_run++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL drain_valid got v=%b busy=%b exp 0/0", out_valid, busy); end
        tests_run++; if (out_data !== prev) begin fails++; $display("FAIL drain_hold got=%h exp=%h", out_data, prev); end
        req_valid = 4'b0001;
        #1;
        tests_run++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL drain_idle_ready got=%b exp=0001", req_ready); end
        req_valid = 4'b0000;
    endtask

    task automatic test_async_reset();
        do_reset();
        req_valid = 4'b1111;
        out_ready = 1'b1;
        req_data  = $urandom;
        #1;
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
        tests_run++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL arst_ready got=%b exp=0000", req_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        tests_run++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL arst_first_grant got=%b exp=0001", req_ready); end
        tick();
        tests_run++; if (out_src !== 2'd0 || out_data !== req_data[7:0]) begin fails++; $display("FAIL arst_out got src=%0d d=%h exp src=0 d=%h", out_src, out_data, req_data[7:0]); end
    endtask

`ifdef ARB4_RR_LOCK_EN
    task automatic test_lock();
        do_reset();
        req_valid = 4'b0001;
        out_ready = 1'b1;
        #1;
        tick();
        req_valid = 4'b1111;
        req_lock  = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL lock_hold[%0d] got=%b exp=0010", k, req_ready); end
            tick();
        end
        req_lock = 4'b0000;
        #1;
        tests_run++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL lock_last got=%b exp=0010", req_ready); end
        tick();
        #1;
        tests_run++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL lock_after got=%b exp=0100", req_ready); end
        tick();
        tests_run++; if (out_src !== 2'd2) begin fails++; $display("FAIL lock_src got=%0d exp=2", out_src); end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            req_valid = (($urandom % 5) == 0) ? 4'b0000 : 4'($urandom);
            out_ready = (($urandom % 4) != 0);
            req_data  = $urandom;
            req_lock  = 4'($urandom);
            #1;
            tests_run++; if (req_ready !== exp_ready()) begin fails++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", k, req_ready, exp_ready()); end
            tick();
            tests_run++; if (out_valid !== m_full || busy !== m_full || out_data !== m_data || out_src !== m_src) begin
                fails++; $display("FAIL rnd_out[%0d] got v=%b b=%b d=%h s=%0d exp v=%b d=%h s=%0d", k, out_valid, busy, out_data, out_src, m_full, m_data, m_src);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_drain();
        test_async_reset();
`ifdef ARB4_RR_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/arb4_rr_ctrl.md
Name: arb4_rr_ctrl

Overview:
- Round-robin arbiter and sequencer that shares one n-bit output channel between four requesters.
- Each requester has a valid/ready handshake. The block selects one requester per transfer, steers its data through a 4:1 select path into an output register, and presents it downstream with its own valid/ready handshake.
- Sits between producer units (register-file ports, ALU result sources) and a single shared consumer bus in the CPU datapath.

Parameters:
- n, BIT_WIDTH, width of each data word in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  4  bit i high = requester i presents a word.
- req_data  in  4*n  requester i data is bits [i*n+n-1 : i*n].
- req_ready  out  4  one-hot or zero; bit i high = requester i word accepted this cycle.
- out_valid  out  1  output register holds a word.
- out_data  out  n  registered output word.
- out_src  out  2  index of the requester that supplied out_data.
- out_ready  in  1  downstream accepts out_data this cycle.
- busy  out  1  equals out_valid; for status and debug.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_src=0, ptr=0, state=IDLE. req_ready=0 while in reset.
- Internal state:
  - 2-bit priority pointer ptr.
  - 2-state FSM: IDLE (output register empty), FULL (output register holds an unaccepted word).
- load_en = (state==IDLE) | (state==FULL & out_ready).
- Arbitration (combinational):
  - Scan req_valid starting at index ptr, then ptr+1, ptr+2, ptr+3, all mod 4.
  - g = first index found with req_valid high; any_req = |req_valid.
- req_ready[i] = load_en & any_req & (i==g). Purely combinational from req_valid, state and out_ready.
- Requesters must not make req_valid depend on req_ready.
- Transfer at requester i occurs when req_valid[i] & req_ready[i].
- On a transfer:
  - out_data <= word of g; out_src <= g; out_valid <= 1.
  - ptr <= (g+1) mod 4; state <= FULL.
- FULL & out_ready & no request: out_valid <= 0, state <= IDLE. out_data and out_src hold their last values.
- FULL & out_ready & request: downstream handshake and new load happen in the same cycle. out_valid stays 1, so throughput is one word per cycle.
- FULL & !out_ready: all registers hold; req_ready=0.
- IDLE & no request: nothing changes.
- Latency: word accepted in cycle N appears on out_data/out_valid in cycle N+1.
- Fairness: a continuously valid requester waits at most 3 other transfers before it is granted.
- Data stability: out_data and out_src never change while out_valid=1 & out_ready=0.
- ptr changes only on a transfer, never on idle cycles.
- Reset mid-transfer: a pending output word is discarded; the requester handshake of the reset cycle does not take effect.

Optional Feature:
- Macro: ARB4_RR_LOCK_EN.
- Defined:
  - Adds input port req_lock (4 bits).
  - On a transfer from g with req_lock[g]=1, ptr <= g instead of g+1, so g keeps top priority for back-to-back bursts.
  - On a transfer from g with req_lock[g]=0, ptr <= g+1 as normal.
- Undefined:
  - Port req_lock is absent.
  - ptr always advances to g+1 mod 4.

Test Plan:
- Reset then single request: rst_n low 2 cycles, release; req_valid=4'b0100, data2=0xA5, out_ready=1.
  - Cycle N: req_ready=4'b0100.
  - Cycle N+1: out_valid=1, out_data=0xA5, out_src=2.
  - Afterwards: ptr=3.
- Round-robin rotation: req_valid=4'b1111 held, out_ready=1 from ptr=0.
  - Grants go 0,1,2,3,0, one per cycle.
  - out_valid stays 1 continuously.
- Backpressure: load a word from src 1, then out_ready=0 for 5 cycles with req_valid=4'b1111.
  - req_ready=0 for all 5 cycles; out_data and out_src stable.
  - On out_ready=1, requester 2 is granted in the same cycle.
- Drain to idle: one word loaded, req_valid=0, out_ready=1.
  - Next cycle out_valid=0, state IDLE, out_data holds its value.
- Async reset mid-stream: assert rst_n low between clock edges while out_valid=1.
  - out_valid=0 immediately and req_ready=0, without waiting for a clock edge.
  - After release, the first grant is from index 0 when req_valid=4'b1111.
- ARB4_RR_LOCK_EN: req_valid=4'b1111, req_lock=4'b0010, ptr=1.
  - Three consecutive grants to 1.
  - Then deassert req_lock[1]: next grant 1, then 2.
